// File: rtl/ex_alu_if.sv
// EX-stage ALU request/response bundle.
// master = upstream issue logic, slave = ex_alu_unit.
interface ex_alu_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [2:0]        ALUCtrl_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic              flush_i;
  logic [DATA_W-1:0] result_o;
  logic              valid_o;
  logic              busy_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    input  result_o, valid_o, busy_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i, flush_i,
    output result_o, valid_o, busy_o
  );
endinterface

// File: rtl/ex_alu_unit.sv
// EX-stage execute unit: 1-cycle ALU ops plus an
// iterative shift-add multiplier that stalls upstream.
module ex_alu_unit #(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  ex_alu_if.slave bus
);

  localparam int K     = DATA_W / MUL_BITS;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int SH_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] pp;
  logic [DATA_W-1:0] acc_sum;
  logic [SH_W-1:0]   shamt;
  logic              busy;
  logic              accept;

  assign busy         = (state_q == S_MUL);
  assign accept       = bus.valid_i && !busy && !bus.flush_i;
  assign shamt        = bus.data2_i[SH_W-1:0];
  assign bus.busy_o   = busy;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

  // single-cycle datapath; MUL and 111 yield zero here
  always_comb begin
    alu_res = '0;
    unique case (bus.ALUCtrl_i)
      3'b000: alu_res = bus.data1_i + bus.data2_i;
      3'b001: alu_res = bus.data1_i - bus.data2_i;
      3'b010: alu_res = bus.data1_i & bus.data2_i;
      3'b011: alu_res = bus.data1_i ^ bus.data2_i;
      3'b101: alu_res = bus.data1_i << shamt;
      3'b110: alu_res = DATA_W'($signed(bus.data1_i) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // one multiplier digit; multiplicand is pre-shifted
  // each step, so no per-step shift of the product
  always_comb begin
    pp      = mcand_q * DATA_W'(mplier_q[MUL_BITS-1:0]);
    acc_sum = acc_q + pp;
  end

  // control FSM and next-state datapath
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (bus.flush_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bus.ALUCtrl_i == 3'b100) begin
              mcand_d  = bus.data1_i;
              mplier_d = bus.data2_i;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end else begin
              result_d = alu_res;
              valid_d  = 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            result_d = acc_sum;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed + table-driven bench for ex_alu_unit.
// Inputs driven and outputs sampled on falling edge.
module tb_ex_alu_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ex_alu_if #(.DATA_W(W)) bus ();

  ex_alu_unit #(
    .DATA_W  (W),
    .MUL_BITS(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(
    input logic [2:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a & b;
      3'b011: r = a ^ b;
      3'b100: r = a * b;
      3'b101: r = a << b[4:0];
      3'b110: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic idle_in();
    bus.valid_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
  endtask

  // full MUL transaction incl. busy length check
  task automatic do_mul(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] exp);
    int cyc;
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b100;
    bus.data1_i   = a;
    bus.data2_i   = b;
    @(negedge clk);
    bus.valid_i = 1'b0;
    cyc = 0;
    while (bus.busy_o && cyc < 20) begin
      if (bus.valid_o) chk("mul_early_valid", 1, 0);
      @(negedge clk);
      cyc++;
    end
    chk("mul_busy_cycles", cyc, 8);
    chk("mul_valid", bus.valid_o, 1);
    chk("mul_result", bus.result_o, exp);
    @(negedge clk);
    chk("mul_valid_once", bus.valid_o, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{3'b000, 32'd5, 32'd7, 32'h0000000C};
    vecs[1] = '{3'b001, 32'd3, 32'd5, 32'hFFFFFFFE};
    vecs[2] = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0,
                32'h00F000F0};
    vecs[3] = '{3'b011, 32'hF0F0F0F0, 32'h0FF00FF0,
                32'hFF00FF00};
    vecs[4] = '{3'b110, 32'h80000000, 32'h24, 32'hF8000000};
    vecs[5] = '{3'b101, 32'h1, 32'h3F, 32'h80000000};
    vecs[6] = '{3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    vecs[7] = '{3'b000, 32'hFFFFFFFF, 32'h1, 32'h0};
    vecs[8] = '{3'b110, 32'h7FFFFFF0, 32'h4, 32'h07FFFFFF};
    vecs[9] = '{3'b101, 32'h12345678, 32'h24, 32'h23456780};

    idle_in();
    rst = 1'b0;
    #12;
    chk("rst_result", bus.result_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // back-to-back single-cycle table
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.valid_i   = 1'b1;
      bus.ALUCtrl_i = vecs[i].op;
      bus.data1_i   = vecs[i].d1;
      bus.data2_i   = vecs[i].d2;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.valid_o, 1);
      chk($sformatf("vec%0d_res", i), bus.result_o,
          vecs[i].exp);
      chk($sformatf("vec%0d_busy", i), bus.busy_o, 0);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("idle_no_valid", bus.valid_o, 0);

    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    do_mul(32'd12345, 32'd6789, 32'h04FED79D);

    // ADD held while MUL busy, taken in MUL valid cycle
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b100;
    bus.data1_i   = 32'd3;
    bus.data2_i   = 32'd5;
    @(negedge clk);
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = 32'd1;
    bus.data2_i   = 32'd1;
    for (int c = 0; c < 20 && bus.busy_o; c++) begin
      if (bus.valid_o) chk("hold_early_valid", 1, 0);
      @(negedge clk);
    end
    chk("hold_mul_valid", bus.valid_o, 1);
    chk("hold_mul_res", bus.result_o, 32'd15);
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("hold_add_valid", bus.valid_o, 1);
    chk("hold_add_res", bus.result_o, 32'd2);
    chk("hold_add_busy", bus.busy_o, 0);
    @(negedge clk);
    chk("hold_after", bus.valid_o, 0);

    // flush beats a simultaneous accept
    bus.valid_i   = 1'b1;
    bus.flush_i   = 1'b1;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = 32'd100;
    bus.data2_i   = 32'd1;
    @(negedge clk);
    idle_in();
    chk("flacc_valid", bus.valid_o, 0);
    chk("flacc_res", bus.result_o, 32'd2);

    // flush at MUL cycle 4
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b100;
    bus.data1_i   = 32'd7;
    bus.data2_i   = 32'd9;
    @(negedge clk);
    bus.valid_i = 1'b0;
    chk("fl_busy_start", bus.busy_o, 1);
    repeat (3) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("fl_busy", bus.busy_o, 0);
    chk("fl_valid", bus.valid_o, 0);
    chk("fl_res", bus.result_o, 32'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.valid_o || bus.busy_o)
        chk("fl_late_activity", 1, 0);
    end

    // async reset mid-MUL
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b100;
    bus.data1_i   = 32'd11;
    bus.data2_i   = 32'd13;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rmid_busy_pre", bus.busy_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rmid_res", bus.result_o, 0);
    chk("rmid_valid", bus.valid_o, 0);
    chk("rmid_busy", bus.busy_o, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.valid_o) chk("rmid_late_valid", 1, 0);
    end

    // random regression vs reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b, e;
      op = 3'($urandom_range(7));
      a  = $urandom;
      b  = $urandom;
      e  = ref_op(op, a, b);
      if (op == 3'b100) begin
        do_mul(a, b, e);
      end else begin
        @(negedge clk);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk($sformatf("rnd%0d_valid", i), bus.valid_o, 1);
        chk($sformatf("rnd%0d_res op%0d", i, op),
            bus.result_o, e);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
